snakes_and_ladders_game: RTL and testbench
==========================================

Name: snakes_and_ladders_game

Overview:
Two-player Snakes and Ladders engine with a built-in automated dice. Each rising edge of `roll` moves the player selected by `player_switch` by the current dice value, then applies any snake or ladder. The block tracks both positions and flags the winner. It is a self-contained top-level game core driven by push-button/switch inputs.

Parameters:
WIN_POS, 100, final square; landing exactly here wins.
DICE_MAX, 6, dice face range is 1..DICE_MAX.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
roll  input  1  level request; one move per 0->1 transition.
player_switch  input  1  1 = player 1 moves, 0 = player 2 moves.
position1  output  7  player 1 square, 0..100.
position2  output  7  player 2 square, 0..100.
win1  output  1  high while position1 == WIN_POS.
win2  output  1  high while position2 == WIN_POS.
dice  output  3  current dice value 1..6 (verification visibility).

Behaviour:
- Reset (async, active-high): position1=position2=0, win1=win2=0, dice=1, roll_q=0. Reset asserted mid-game aborts immediately, with no partial move.
- Dice: free-running counter 1,2,3,4,5,6,1,... advancing every clk edge while not in reset. Deterministic; the value used for a move is `dice` as sampled at the move edge.
- Roll detection: register roll_q <= roll each edge. A move occurs on an edge where roll==1 and roll_q==0. Holding roll high produces no further moves; a new move requires roll to drop and rise again.
- Move (same edge, 1-cycle latency; new position visible after that edge):
  - Select P = player_switch ? player 1 : player 2.
  - sum = pos_P + dice, using 8-bit arithmetic internally.
  - If sum > WIN_POS: pos_P is unchanged (exact-landing rule).
  - Otherwise pos_P = board_map(sum).
  - The other player is untouched.
- board_map: single lookup; destinations are never sources, so no chaining.
  - Ladders: 4->14, 9->31, 20->38, 28->84, 40->59, 51->67, 63->81, 71->91.
  - Snakes: 17->7, 54->34, 62->19, 64->60, 87->24, 93->73, 95->75, 99->78.
  - All other squares map to themselves.
- Win:
  - winN is combinational from the registered position: winN = (positionN == WIN_POS).
  - Once either win is high, the game is frozen: no further moves until reset. The dice keeps counting.
- The dice value and player_switch are sampled on the move edge. Changing player_switch without a roll edge has no effect.
- Turn order is not enforced in hardware; the same player may move repeatedly.
- Outputs change only on clk edges or reset.

Decomposition:
- Package snl_pkg:
  - WIN_POS, DICE_MAX, position width (7).
  - The snake/ladder table as constant arrays (source, destination) plus a board-map function.
- Sub-module snl_board_map: purely combinational, 7-bit square in, 7-bit mapped square out.
- Dice counter and roll edge detect stay inline in the top.

Test Plan:
- Reset held, then released -> positions 0/0, win1=win2=0, dice=1. After release, dice steps 2,3,4,5,6,1 on successive edges.
- player_switch=1, roll pulse with dice=4 at the move edge, from 0 -> position1=14 (ladder), position2=0. A second edge with roll still high -> no change.
- player_switch=0, roll with dice=3 from position2=14 -> position2=7 (snake 17->7). position1 unchanged.
- Player 1 at 97, roll with dice=4 -> stays 97 (overshoot). Roll with dice=3 -> position1=100, win1=1.
- After win1=1, further roll pulses for either player -> positions frozen, win2=0, dice keeps counting. Async reset pulse mid-cycle -> immediately 0/0/0/0.
- Player 2 at 94, roll with dice=5 -> 99 maps to 78. Alternating player_switch across 20 pulses -> only the selected player changes each pulse.

Source files
------------

// File: rtl/snl_pkg.sv
// Shared constants, types and the snake/ladder table for the two-player
// snakes and ladders game core.
package snl_pkg;

  localparam int unsigned POS_W    = 7;
  localparam int unsigned SUM_W    = 8;
  localparam int unsigned DICE_W   = 3;
  localparam int unsigned WIN_POS  = 100;
  localparam int unsigned DICE_MAX = 6;
  localparam int unsigned N_JUMPS  = 16;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    PLAYER_2 = 1'b0,
    PLAYER_1 = 1'b1
  } player_e;

  // Ladders first, then snakes; no destination is also a source.
  localparam pos_t JUMP_SRC [N_JUMPS] = '{
    7'd4,  7'd9,  7'd20, 7'd28, 7'd40, 7'd51, 7'd63, 7'd71,
    7'd17, 7'd54, 7'd62, 7'd64, 7'd87, 7'd93, 7'd95, 7'd99
  };

  localparam pos_t JUMP_DST [N_JUMPS] = '{
    7'd14, 7'd31, 7'd38, 7'd84, 7'd59, 7'd67, 7'd81, 7'd91,
    7'd7,  7'd34, 7'd19, 7'd60, 7'd24, 7'd73, 7'd75, 7'd78
  };

  function automatic pos_t board_map(input pos_t square);
    pos_t result;
    result = square;
    for (int unsigned i = 0; i < N_JUMPS; i++) begin
      if (square == JUMP_SRC[i]) result = JUMP_DST[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/snl_board_map.sv
// Combinational square remap: applies a single snake or ladder, if any.
module snl_board_map
  import snl_pkg::*;
(
  input  logic [POS_W-1:0] square,
  output logic [POS_W-1:0] mapped_c
);

  always_comb mapped_c = board_map(square);

endmodule

// File: rtl/snakes_and_ladders_game.sv
// Two-player snakes and ladders core: free-running dice, roll edge detect,
// exact-landing moves with board remap, and a win freeze.
module snakes_and_ladders_game
  import snl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              roll,
  input  logic              player_switch,
  output logic [POS_W-1:0]  position1,
  output logic [POS_W-1:0]  position2,
  output logic              win1,
  output logic              win2,
  output logic [DICE_W-1:0] dice
);

  logic              roll_q;
  logic              frozen;
  logic              move_en;
  player_e           player;
  logic [POS_W-1:0]  cur_pos;
  logic [SUM_W-1:0]  sum;
  logic [POS_W-1:0]  mapped;
  logic [POS_W-1:0]  pos1_d;
  logic [POS_W-1:0]  pos2_d;
  logic [DICE_W-1:0] dice_d;

  assign win1 = (position1 == POS_W'(WIN_POS));
  assign win2 = (position2 == POS_W'(WIN_POS));

  // Candidate move for the selected player; overshooting the last square is a no-op.
  always_comb begin
    player  = player_e'(player_switch);
    cur_pos = (player == PLAYER_1) ? position1 : position2;
    sum     = SUM_W'(cur_pos) + SUM_W'(dice);
    frozen  = win1 | win2;
    move_en = roll & ~roll_q & ~frozen & (sum <= SUM_W'(WIN_POS));
  end

  snl_board_map u_board_map (
    .square   (sum[POS_W-1:0]),
    .mapped_c (mapped)
  );

  always_comb begin
    pos1_d = position1;
    pos2_d = position2;
    dice_d = (dice == DICE_W'(DICE_MAX)) ? DICE_W'(1) : dice + DICE_W'(1);
    if (move_en) begin
      if (player == PLAYER_1) pos1_d = mapped;
      else                    pos2_d = mapped;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position1 <= '0;
      position2 <= '0;
      dice      <= DICE_W'(1);
      roll_q    <= 1'b0;
    end else begin
      position1 <= pos1_d;
      position2 <= pos2_d;
      dice      <= dice_d;
      roll_q    <= roll;
    end
  end

endmodule

// File: tb/tb_snakes_and_ladders_game.sv
// Directed self-checking bench for snakes_and_ladders_game with a small
// reference model of positions, dice and win freeze.
module tb_snakes_and_ladders_game;

  logic       clk;
  logic       reset;
  logic       roll;
  logic       player_switch;
  logic [6:0] position1;
  logic [6:0] position2;
  logic       win1;
  logic       win2;
  logic [2:0] dice;

  int total = 0;
  int bad   = 0;
  int exp_dice;
  int m_p1;
  int m_p2;

  snakes_and_ladders_game dut (
    .clk           (clk),
    .reset         (reset),
    .roll          (roll),
    .player_switch (player_switch),
    .position1     (position1),
    .position2     (position2),
    .win1          (win1),
    .win2          (win2),
    .dice          (dice)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int map_sq(input int s);
    case (s)
      4:  return 14;  9:  return 31;  20: return 38;  28: return 84;
      40: return 59;  51: return 67;  63: return 81;  71: return 91;
      17: return 7;   54: return 34;  62: return 19;  64: return 60;
      87: return 24;  93: return 73;  95: return 75;  99: return 78;
      default: return s;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_p1"}, int'(position1), m_p1);
    check({tag, "_p2"}, int'(position2), m_p2);
    check({tag, "_w1"}, int'(win1), (m_p1 == 100) ? 1 : 0);
    check({tag, "_w2"}, int'(win2), (m_p2 == 100) ? 1 : 0);
  endtask

  // One clock edge, sampled 1ns after; the dice is checked on every step.
  task automatic step();
    @(posedge clk);
    #1;
    exp_dice = (exp_dice == 6) ? 1 : exp_dice + 1;
    check("dice", int'(dice), exp_dice);
  endtask

  // Wait (roll low) until the dice shows d, then move player p on that edge.
  task automatic roll_on(input bit p1, input int d, input bit hold);
    int cur;
    int sum;
    roll = 1'b0;
    while (exp_dice != d) step();
    player_switch = p1;
    roll = 1'b1;
    step();
    if (m_p1 != 100 && m_p2 != 100) begin
      cur = p1 ? m_p1 : m_p2;
      sum = cur + d;
      if (sum <= 100) begin
        if (p1) m_p1 = map_sq(sum);
        else    m_p2 = map_sq(sum);
      end
    end
    check_state("move");
    if (hold) begin
      step();
      check_state("hold");
    end
    roll = 1'b0;
    player_switch = ~p1;
    step();
    check_state("idle");
  endtask

  initial begin
    reset = 1'b1;
    roll = 1'b0;
    player_switch = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    exp_dice = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p1", int'(position1), 0);
    check("rst_p2", int'(position2), 0);
    check("rst_w1", int'(win1), 0);
    check("rst_w2", int'(win2), 0);
    check("rst_dice", int'(dice), 1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("dice_wrap", int'(dice), 1);

    // Ladder 4->14 for player 1, roll held high for an extra edge
    roll_on(1'b1, 4, 1'b1);
    check("p1_ladder", int'(position1), 14);
    check("p2_untouched", int'(position2), 0);
    roll_on(1'b0, 4, 1'b0);
    roll_on(1'b0, 3, 1'b0);
    check("p2_snake", int'(position2), 7);
    check("p1_kept", int'(position1), 14);

    // Player 1 climbs to 97: 38, 59, 81, 86, 92, 97
    roll_on(1'b1, 6, 1'b0);
    roll_on(1'b1, 2, 1'b0);
    roll_on(1'b1, 4, 1'b0);
    roll_on(1'b1, 5, 1'b0);
    roll_on(1'b1, 6, 1'b0);
    roll_on(1'b1, 5, 1'b0);
    check("p1_97", int'(position1), 97);
    roll_on(1'b1, 4, 1'b0);
    check("p1_overshoot", int'(position1), 97);
    roll_on(1'b1, 3, 1'b0);
    check("p1_win_pos", int'(position1), 100);
    check("win1", int'(win1), 1);

    // Frozen after a win
    roll_on(1'b0, 2, 1'b0);
    roll_on(1'b1, 1, 1'b0);
    check("frozen_p1", int'(position1), 100);
    check("frozen_p2", int'(position2), 7);
    check("frozen_w2", int'(win2), 0);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_p1", int'(position1), 0);
    check("arst_p2", int'(position2), 0);
    check("arst_w1", int'(win1), 0);
    check("arst_dice", int'(dice), 1);
    @(negedge clk);
    reset = 1'b0;
    roll = 1'b0;
    exp_dice = 1;
    m_p1 = 0;
    m_p2 = 0;

    // Player 2 to 94, then 99 snakes down to 78
    roll_on(1'b0, 4, 1'b0);
    roll_on(1'b0, 6, 1'b0);
    roll_on(1'b0, 2, 1'b0);
    roll_on(1'b0, 4, 1'b0);
    roll_on(1'b0, 5, 1'b0);
    roll_on(1'b0, 6, 1'b0);
    roll_on(1'b0, 2, 1'b0);
    check("p2_94", int'(position2), 94);
    roll_on(1'b0, 5, 1'b0);
    check("p2_99_snake", int'(position2), 78);
    check("p1_zero", int'(position1), 0);

    // Alternating players over 20 pulses
    for (int i = 0; i < 20; i++) begin
      roll_on(i[0], ((i * 5) % 6) + 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
